// File: rtl/uart_xcvr_if.sv
// uart_xcvr_if
//  Byte-level handshake bundle between a host and the UART transceiver core.
//  Signals:
//   tx_valid / tx_ready / tx_data      host offers a byte to transmit
//   rx_valid / rx_data                 one-cycle pulse with a received byte
//   rx_par_err / rx_frm_err            frame errors, qualified by rx_valid
//   rx_timeout                         one-cycle pulse on RX idle timeout
//  Modports: master = host side, slave = transceiver core side.
interface uart_xcvr_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_par_err;
    logic       rx_frm_err;
    logic       rx_timeout;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, rx_valid, rx_data, rx_par_err, rx_frm_err, rx_timeout
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, rx_valid, rx_data, rx_par_err, rx_frm_err, rx_timeout
    );
endinterface

// File: rtl/uart_xcvr_core.sv
// uart_xcvr_core
//  UART transmitter/receiver with 16x oversampling and runtime framing:
//  5-8 data bits, parity none/even/odd/stick, 1/1.5/2 stop bits.
//  RX detects false starts, parity and stop errors and idle timeout; the core
//  keeps saturating frame statistics.
//  Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_divisor         16x tick every cfg_divisor+1 clk cycles
//   cfg_data_bits       data bits = cfg_data_bits+5
//   cfg_stop2           2 stop bits (1.5 when 5 data bits)
//   cfg_parity_en/cfg_even/cfg_stick  parity selection
//   cfg_timeout         RX idle timeout in bit times, 0 disables
//   clr_counts          zero the statistics counters
//   txd / rxd           serial line out (idle high) / in (asynchronous)
//   rx_count/tx_count/err_count  saturating frame statistics
//   host                byte handshake interface (slave side)
module uart_xcvr_core #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_divisor,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_stop2,
    input  logic             cfg_parity_en,
    input  logic             cfg_even,
    input  logic             cfg_stick,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             clr_counts,
    output logic             txd,
    input  logic             rxd,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] err_count,
    uart_xcvr_if.slave       host
);

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
        TX_PAR  = 3'd3, TX_STOP1 = 3'd4, TX_STOP2 = 3'd5
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
        RX_PAR  = 3'd3, RX_STOP1 = 3'd4, RX_STOP2 = 3'd5
    } rx_state_t;

    // Mask selecting the active data bits for a given data-bit setting.
    function automatic logic [7:0] data_mask(input logic [1:0] db);
        case (db)
            2'd0:    data_mask = 8'h1F;
            2'd1:    data_mask = 8'h3F;
            2'd2:    data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    endfunction

    // Parity bit over the active data bits; stick mode forces ~even.
    function automatic logic par_calc(input logic [7:0] d, input logic [1:0] db,
                                      input logic even, input logic stick);
        logic [7:0] m;
        m = d & data_mask(db);
        if (stick)      par_calc = ~even;
        else if (even)  par_calc = ^m;
        else            par_calc = ~(^m);
    endfunction

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_lat_r;
    logic             tick_s;

    assign tick_s = (div_cnt_r == div_lat_r);

    // Free-running divider; the divisor is re-sampled only at reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
            div_lat_r <= cfg_divisor;
        end else if (tick_s) begin
            div_cnt_r <= '0;
            div_lat_r <= cfg_divisor;
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t  tx_state_r, tx_state_nx;
    logic [3:0] tx_tick_r, tx_tick_nx;
    logic [2:0] tx_bit_r, tx_bit_nx;
    logic [7:0] tx_shift_r, tx_shift_nx;
    logic [1:0] tx_db_r, tx_db_nx;
    logic       tx_par_r, tx_par_nx;
    logic       tx_pen_r, tx_pen_nx;
    logic       tx_stop2_r, tx_stop2_nx;
    logic       tx_half_r, tx_half_nx;
    logic       txd_r, txd_nx;
    logic       tx_ready_r;
    logic       tx_done_s;
    logic       tx_bit_end_s;
    logic [2:0] tx_last_s;

    // A half-length second stop bit ends after 8 ticks instead of 16.
    assign tx_bit_end_s = tick_s &&
        (tx_tick_r == (((tx_state_r == TX_STOP2) && tx_half_r) ? 4'd7 : 4'd15));
    assign tx_last_s = 3'd4 + {1'b0, tx_db_r};

    // TX next-state, frame latching and next serial level.
    always_comb begin
        tx_state_nx = tx_state_r;
        tx_bit_nx   = tx_bit_r;
        tx_shift_nx = tx_shift_r;
        tx_db_nx    = tx_db_r;
        tx_par_nx   = tx_par_r;
        tx_pen_nx   = tx_pen_r;
        tx_stop2_nx = tx_stop2_r;
        tx_half_nx  = tx_half_r;
        tx_done_s   = 1'b0;
        txd_nx      = 1'b1;
        if (tx_bit_end_s)  tx_tick_nx = 4'd0;
        else if (tick_s)   tx_tick_nx = tx_tick_r + 4'd1;
        else               tx_tick_nx = tx_tick_r;

        case (tx_state_r)
            TX_IDLE: begin
                tx_tick_nx = 4'd0;
                if (host.tx_valid && tx_ready_r) begin
                    tx_state_nx = TX_START;
                    tx_shift_nx = host.tx_data & data_mask(cfg_data_bits);
                    tx_db_nx    = cfg_data_bits;
                    tx_par_nx   = par_calc(host.tx_data, cfg_data_bits, cfg_even, cfg_stick);
                    tx_pen_nx   = cfg_parity_en;
                    tx_stop2_nx = cfg_stop2;
                    tx_half_nx  = cfg_stop2 && (cfg_data_bits == 2'd0);
                    tx_bit_nx   = 3'd0;
                end else begin
                    tx_state_nx = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_bit_end_s) tx_state_nx = TX_DATA;
                else              tx_state_nx = TX_START;
            end
            TX_DATA: begin
                if (tx_bit_end_s) begin
                    tx_shift_nx = {1'b0, tx_shift_r[7:1]};
                    if (tx_bit_r == tx_last_s) tx_state_nx = tx_pen_r ? TX_PAR : TX_STOP1;
                    else                       tx_bit_nx   = tx_bit_r + 3'd1;
                end else begin
                    tx_shift_nx = tx_shift_r;
                end
            end
            TX_PAR: begin
                if (tx_bit_end_s) tx_state_nx = TX_STOP1;
                else              tx_state_nx = TX_PAR;
            end
            TX_STOP1: begin
                if (tx_bit_end_s) begin
                    if (tx_stop2_r) begin
                        tx_state_nx = TX_STOP2;
                    end else begin
                        tx_state_nx = TX_IDLE;
                        tx_done_s   = 1'b1;
                    end
                end else begin
                    tx_state_nx = TX_STOP1;
                end
            end
            TX_STOP2: begin
                if (tx_bit_end_s) begin
                    tx_state_nx = TX_IDLE;
                    tx_done_s   = 1'b1;
                end else begin
                    tx_state_nx = TX_STOP2;
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase

        // Serial level is registered, so it follows the state being entered.
        case (tx_state_nx)
            TX_START: txd_nx = 1'b0;
            TX_DATA:  txd_nx = tx_shift_nx[0];
            TX_PAR:   txd_nx = tx_par_nx;
            default:  txd_nx = 1'b1;
        endcase
    end

    // TX state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_db_r    <= 2'd0;
            tx_par_r   <= 1'b0;
            tx_pen_r   <= 1'b0;
            tx_stop2_r <= 1'b0;
            tx_half_r  <= 1'b0;
            txd_r      <= 1'b1;
            tx_ready_r <= 1'b0;
        end else begin
            tx_state_r <= tx_state_nx;
            tx_tick_r  <= tx_tick_nx;
            tx_bit_r   <= tx_bit_nx;
            tx_shift_r <= tx_shift_nx;
            tx_db_r    <= tx_db_nx;
            tx_par_r   <= tx_par_nx;
            tx_pen_r   <= tx_pen_nx;
            tx_stop2_r <= tx_stop2_nx;
            tx_half_r  <= tx_half_nx;
            txd_r      <= txd_nx;
            tx_ready_r <= (tx_state_nx == TX_IDLE);
        end
    end

    assign txd           = txd_r;
    assign host.tx_ready = tx_ready_r;

    // ---------------- receiver ----------------
    logic       rx_meta_r, rx_sync_r, rx_prev_r;
    logic       rx_fall_s;
    rx_state_t  rx_state_r, rx_state_nx;
    logic [3:0] rx_tick_r, rx_tick_nx;
    logic [2:0] rx_bit_r, rx_bit_nx;
    logic [7:0] rx_acc_r, rx_acc_nx;
    logic [1:0] rx_db_r, rx_db_nx;
    logic       rx_pen_r, rx_pen_nx;
    logic       rx_even_r, rx_even_nx;
    logic       rx_stick_r, rx_stick_nx;
    logic       rx_stop2_r, rx_stop2_nx;
    logic       rx_perr_r, rx_perr_nx;
    logic       rx_ferr_r, rx_ferr_nx;
    logic       rx_sample_s;
    logic       rx_deliver_s;
    logic       rx_err_s;
    logic [2:0] rx_last_s;
    logic       rx_valid_r, rx_par_err_r, rx_frm_err_r;
    logic [7:0] rx_data_r;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Needs a high before the low, so a line stuck low cannot re-trigger.
    assign rx_fall_s   = rx_prev_r & ~rx_sync_r;
    // Start is sampled 8 ticks in, every later bit 16 ticks after that.
    assign rx_sample_s = tick_s &&
        (rx_tick_r == ((rx_state_r == RX_START) ? 4'd7 : 4'd15));
    assign rx_last_s   = 3'd4 + {1'b0, rx_db_r};

    // RX next-state, sampling and frame checking.
    always_comb begin
        rx_state_nx  = rx_state_r;
        rx_bit_nx    = rx_bit_r;
        rx_acc_nx    = rx_acc_r;
        rx_db_nx     = rx_db_r;
        rx_pen_nx    = rx_pen_r;
        rx_even_nx   = rx_even_r;
        rx_stick_nx  = rx_stick_r;
        rx_stop2_nx  = rx_stop2_r;
        rx_perr_nx   = rx_perr_r;
        rx_ferr_nx   = rx_ferr_r;
        rx_deliver_s = 1'b0;
        if (rx_sample_s)  rx_tick_nx = 4'd0;
        else if (tick_s)  rx_tick_nx = rx_tick_r + 4'd1;
        else              rx_tick_nx = rx_tick_r;

        case (rx_state_r)
            RX_IDLE: begin
                rx_tick_nx = 4'd0;
                if (rx_fall_s) begin
                    rx_state_nx = RX_START;
                    rx_bit_nx   = 3'd0;
                    rx_acc_nx   = 8'h00;
                    rx_db_nx    = cfg_data_bits;
                    rx_pen_nx   = cfg_parity_en;
                    rx_even_nx  = cfg_even;
                    rx_stick_nx = cfg_stick;
                    rx_stop2_nx = cfg_stop2;
                    rx_perr_nx  = 1'b0;
                    rx_ferr_nx  = 1'b0;
                end else begin
                    rx_state_nx = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_sample_s) rx_state_nx = rx_sync_r ? RX_IDLE : RX_DATA;
                else             rx_state_nx = RX_START;
            end
            RX_DATA: begin
                if (rx_sample_s) begin
                    rx_acc_nx[rx_bit_r] = rx_sync_r;
                    if (rx_bit_r == rx_last_s) rx_state_nx = rx_pen_r ? RX_PAR : RX_STOP1;
                    else                       rx_bit_nx   = rx_bit_r + 3'd1;
                end else begin
                    rx_state_nx = RX_DATA;
                end
            end
            RX_PAR: begin
                if (rx_sample_s) begin
                    rx_perr_nx  = rx_sync_r ^ par_calc(rx_acc_r, rx_db_r, rx_even_r, rx_stick_r);
                    rx_state_nx = RX_STOP1;
                end else begin
                    rx_state_nx = RX_PAR;
                end
            end
            RX_STOP1: begin
                if (rx_sample_s) begin
                    rx_ferr_nx = rx_ferr_r | ~rx_sync_r;
                    if (rx_stop2_r) begin
                        rx_state_nx = RX_STOP2;
                    end else begin
                        rx_state_nx  = RX_IDLE;
                        rx_deliver_s = 1'b1;
                    end
                end else begin
                    rx_state_nx = RX_STOP1;
                end
            end
            RX_STOP2: begin
                if (rx_sample_s) begin
                    rx_ferr_nx   = rx_ferr_r | ~rx_sync_r;
                    rx_state_nx  = RX_IDLE;
                    rx_deliver_s = 1'b1;
                end else begin
                    rx_state_nx = RX_STOP2;
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase

        rx_err_s = rx_perr_nx | rx_ferr_nx;
    end

    // RX state and registered frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r   <= RX_IDLE;
            rx_tick_r    <= 4'd0;
            rx_bit_r     <= 3'd0;
            rx_acc_r     <= 8'h00;
            rx_db_r      <= 2'd0;
            rx_pen_r     <= 1'b0;
            rx_even_r    <= 1'b0;
            rx_stick_r   <= 1'b0;
            rx_stop2_r   <= 1'b0;
            rx_perr_r    <= 1'b0;
            rx_ferr_r    <= 1'b0;
            rx_valid_r   <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_par_err_r <= 1'b0;
            rx_frm_err_r <= 1'b0;
        end else begin
            rx_state_r <= rx_state_nx;
            rx_tick_r  <= rx_tick_nx;
            rx_bit_r   <= rx_bit_nx;
            rx_acc_r   <= rx_acc_nx;
            rx_db_r    <= rx_db_nx;
            rx_pen_r   <= rx_pen_nx;
            rx_even_r  <= rx_even_nx;
            rx_stick_r <= rx_stick_nx;
            rx_stop2_r <= rx_stop2_nx;
            rx_perr_r  <= rx_perr_nx;
            rx_ferr_r  <= rx_ferr_nx;
            rx_valid_r <= rx_deliver_s;
            if (rx_deliver_s) begin
                rx_data_r    <= rx_acc_r;
                rx_par_err_r <= rx_perr_nx;
                rx_frm_err_r <= rx_ferr_nx;
            end
        end
    end

    // ---------------- idle timeout ----------------
    logic [3:0]       tmo_tick_r;
    logic [TMO_W-1:0] tmo_bits_r;
    logic             tmo_armed_r;
    logic             tmo_pulse_r;
    logic             tmo_run_s;
    logic             tmo_fire_s;

    assign tmo_run_s  = (rx_state_r == RX_IDLE) && rx_sync_r && tmo_armed_r &&
                        (cfg_timeout != '0);
    assign tmo_fire_s = tmo_run_s && (tmo_bits_r >= cfg_timeout);

    // Bit-time counter while idle-high; fires once, re-armed by a frame or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_tick_r  <= 4'd0;
            tmo_bits_r  <= '0;
            tmo_armed_r <= 1'b1;
            tmo_pulse_r <= 1'b0;
        end else if (clr_counts || rx_deliver_s) begin
            tmo_tick_r  <= 4'd0;
            tmo_bits_r  <= '0;
            tmo_armed_r <= 1'b1;
            tmo_pulse_r <= 1'b0;
        end else if (tmo_fire_s) begin
            tmo_tick_r  <= 4'd0;
            tmo_bits_r  <= '0;
            tmo_armed_r <= 1'b0;
            tmo_pulse_r <= 1'b1;
        end else if (!tmo_run_s) begin
            tmo_tick_r  <= 4'd0;
            tmo_bits_r  <= '0;
            tmo_pulse_r <= 1'b0;
        end else begin
            tmo_pulse_r <= 1'b0;
            if (tick_s) begin
                tmo_tick_r <= tmo_tick_r + 4'd1;
                if (tmo_tick_r == 4'd15) tmo_bits_r <= tmo_bits_r + 1'b1;
            end
        end
    end

    // ---------------- statistics ----------------
    // Saturating counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            rx_count  <= '0;
            tx_count  <= '0;
            err_count <= '0;
        end else begin
            if (rx_deliver_s && !(&rx_count)) rx_count <= rx_count + 1'b1;
            if (tx_done_s && !(&tx_count))    tx_count <= tx_count + 1'b1;
            if (((rx_deliver_s && rx_err_s) || tmo_fire_s) && !(&err_count))
                err_count <= err_count + 1'b1;
        end
    end

    assign host.rx_valid   = rx_valid_r;
    assign host.rx_data    = rx_data_r;
    assign host.rx_par_err = rx_par_err_r;
    assign host.rx_frm_err = rx_frm_err_r;
    assign host.rx_timeout = tmo_pulse_r;

endmodule

// File: tb/tb_uart_xcvr_core.sv
// tb_uart_xcvr_core
//  Directed bench for uart_xcvr_core: loopback and hand-built RX frames with
//  hand-computed expected bytes, errors, frame lengths and counter values.
//  Counters are built 4 bits wide so saturation is reachable quickly.
module tb_uart_xcvr_core;
    localparam int CNT_W = 4;

    logic             test_clk;
    logic             rst;
    logic [15:0]      cfg_divisor;
    logic [1:0]       cfg_data_bits;
    logic             cfg_stop2;
    logic             cfg_parity_en;
    logic             cfg_even;
    logic             cfg_stick;
    logic [15:0]      cfg_timeout;
    logic             clr_counts;
    logic             txd;
    logic             rxd;
    logic             rxd_drv;
    logic             loop_en;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Received frames logged as {frm_err, par_err, data}.
    logic [9:0] rx_log [0:63];
    int         rx_wr = 0;
    int         n_tmo = 0;

    uart_xcvr_if u_if();

    assign rxd = loop_en ? txd : rxd_drv;

    uart_xcvr_core #(.DIV_W(16), .CNT_W(CNT_W), .TMO_W(16)) u_dut (
        .clk           (test_clk),
        .rst           (rst),
        .cfg_divisor   (cfg_divisor),
        .cfg_data_bits (cfg_data_bits),
        .cfg_stop2     (cfg_stop2),
        .cfg_parity_en (cfg_parity_en),
        .cfg_even      (cfg_even),
        .cfg_stick     (cfg_stick),
        .cfg_timeout   (cfg_timeout),
        .clr_counts    (clr_counts),
        .txd           (txd),
        .rxd           (rxd),
        .rx_count      (rx_count),
        .tx_count      (tx_count),
        .err_count     (err_count),
        .host          (u_if)
    );

    initial test_clk = 1'b0;
    always #5 test_clk = ~test_clk;

    // Log every delivered frame and every timeout pulse.
    always @(negedge test_clk) begin
        if (u_if.rx_valid && rx_wr < 64) begin
            rx_log[rx_wr] <= {u_if.rx_frm_err, u_if.rx_par_err, u_if.rx_data};
            rx_wr <= rx_wr + 1;
        end
        if (u_if.rx_timeout) n_tmo <= n_tmo + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte and return on the negedge after it is accepted.
    task automatic tx_accept(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge test_clk);
        while (!u_if.tx_ready && n < 1000) begin
            @(negedge test_clk);
            n++;
        end
        if (n >= 1000) check_eq("tx_ready_wait", 32'd0, 32'd1);
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = d;
        @(negedge test_clk);
        u_if.tx_valid = 1'b0;
    endtask

    // Send a byte; report clk count until tx_ready returns and txd at probe_at.
    task automatic send_tx(input logic [7:0] d, input int probe_at,
                           output int cyc, output logic probe);
        cyc   = 0;
        probe = 1'b1;
        tx_accept(d);
        while (cyc < 1000) begin
            @(posedge test_clk);
            cyc++;
            @(negedge test_clk);
            if (cyc == probe_at) probe = txd;
            if (u_if.tx_ready) break;
        end
    endtask

    // Drive a raw frame onto rxd, LSB first, 16 clk per bit, then idle high.
    task automatic drive_frame(input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rxd_drv = bits[i];
            repeat (16) @(negedge test_clk);
        end
        rxd_drv = 1'b1;
        repeat (20) @(negedge test_clk);
    endtask

    initial begin
        int   cyc;
        int   n;
        logic pv;

        rst           = 1'b1;
        cfg_divisor   = 16'd0;
        cfg_data_bits = 2'd3;
        cfg_stop2     = 1'b0;
        cfg_parity_en = 1'b0;
        cfg_even      = 1'b0;
        cfg_stick     = 1'b0;
        cfg_timeout   = 16'd0;
        clr_counts    = 1'b0;
        rxd_drv       = 1'b1;
        loop_en       = 1'b1;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge test_clk);
        check_eq("rst_txd", 32'(txd), 32'd1);
        check_eq("rst_tx_ready", 32'(u_if.tx_ready), 32'd0);
        check_eq("rst_rx_valid", 32'(u_if.rx_valid), 32'd0);
        check_eq("rst_counts", {20'd0, rx_count, tx_count, err_count}, 32'd0);
        rst = 1'b0;
        @(negedge test_clk);
        check_eq("ready_after_rst", 32'(u_if.tx_ready), 32'd1);

        // 1: loopback 8N1 0xA5
        send_tx(8'hA5, 0, cyc, pv);
        repeat (10) @(negedge test_clk);
        check_eq("t1_frame_clk", cyc, 32'd160);
        check_eq("t1_rx_n", rx_wr, 32'd1);
        check_eq("t1_rx", 32'(rx_log[0]), 32'h0A5);
        check_eq("t1_counts", {20'd0, rx_count, tx_count, err_count}, 32'h110);

        // 2: loopback 7E2, parity bit of 0x55 is 0; then back-to-back
        cfg_data_bits = 2'd2;
        cfg_parity_en = 1'b1;
        cfg_even      = 1'b1;
        cfg_stop2     = 1'b1;
        send_tx(8'h55, 136, cyc, pv);
        check_eq("t2_par_bit", 32'(pv), 32'd0);
        check_eq("t2_frame_clk", cyc, 32'd176);
        send_tx(8'h7F, 0, cyc, pv);
        send_tx(8'h00, 0, cyc, pv);
        repeat (10) @(negedge test_clk);
        check_eq("t2_rx_n", rx_wr, 32'd4);
        check_eq("t2_rx0", 32'(rx_log[1]), 32'h055);
        check_eq("t2_rx1", 32'(rx_log[2]), 32'h07F);
        check_eq("t2_rx2", 32'(rx_log[3]), 32'h000);

        // stick parity, even=1: bit is 0 although even parity of 0x01 is 1
        cfg_data_bits = 2'd3;
        cfg_stick     = 1'b1;
        cfg_stop2     = 1'b0;
        send_tx(8'h01, 152, cyc, pv);
        repeat (10) @(negedge test_clk);
        check_eq("t2_stick_bit", 32'(pv), 32'd0);
        check_eq("t2_stick_rx", 32'(rx_log[4]), 32'h001);
        check_eq("t2_counts", {20'd0, rx_count, tx_count, err_count}, 32'h550);

        // 3: driven 8O1 0x3C with parity 0 (odd parity needs 1)
        loop_en   = 1'b0;
        cfg_stick = 1'b0;
        cfg_even  = 1'b0;
        drive_frame(16'h0478, 11);
        check_eq("t3_rx", 32'(rx_log[5]), 32'h13C);
        check_eq("t3_err_count", 32'(err_count), 32'd1);
        check_eq("t3_rx_count", 32'(rx_count), 32'd6);

        // 4: driven 5N2 0x15 with stop1 low, then tx 5N2 with 24-tick stop
        cfg_data_bits = 2'd0;
        cfg_parity_en = 1'b0;
        cfg_stop2     = 1'b1;
        drive_frame(16'h00AA, 8);
        check_eq("t4_rx", 32'(rx_log[6]), 32'h215);
        check_eq("t4_err_count", 32'(err_count), 32'd2);
        send_tx(8'hEA, 40, cyc, pv);
        check_eq("t4_frame_clk", cyc, 32'd120);
        check_eq("t4_data_bit1", 32'(pv), 32'd1);
        check_eq("t4_tx_count", 32'(tx_count), 32'd6);

        // 5: 4-clk low glitch is a false start; then 3-bit-time idle timeout
        rxd_drv = 1'b0;
        repeat (4) @(negedge test_clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge test_clk);
        check_eq("t5_glitch_rx_n", rx_wr, 32'd7);
        cfg_timeout = 16'd3;
        n = 0;
        while (n < 200) begin
            @(posedge test_clk);
            n++;
            @(negedge test_clk);
            if (u_if.rx_timeout) break;
        end
        check_eq("t5_tmo_latency", n, 32'd49);
        check_eq("t5_tmo_err_count", 32'(err_count), 32'd3);
        repeat (200) @(negedge test_clk);
        check_eq("t5_tmo_once", n_tmo, 32'd1);
        cfg_timeout = 16'd0;

        // 6: reset during TX and RX data bits
        loop_en       = 1'b1;
        cfg_data_bits = 2'd3;
        cfg_stop2     = 1'b0;
        tx_accept(8'hA5);
        repeat (40) @(negedge test_clk);
        check_eq("t6_txd_pre_rst", 32'(txd), 32'd0);
        rst = 1'b1;
        @(negedge test_clk);
        check_eq("t6_txd_rst", 32'(txd), 32'd1);
        rst = 1'b0;
        repeat (300) @(negedge test_clk);
        check_eq("t6_no_rx", rx_wr, 32'd7);
        check_eq("t6_counts", {20'd0, rx_count, tx_count, err_count}, 32'd0);

        // saturation: 17 loopback 5N1 frames into 4-bit counters
        cfg_data_bits = 2'd0;
        for (int i = 0; i < 17; i++) begin
            send_tx(8'(i), 0, cyc, pv);
        end
        repeat (10) @(negedge test_clk);
        check_eq("sat_tx_count", 32'(tx_count), 32'hF);
        check_eq("sat_rx_count", 32'(rx_count), 32'hF);
        check_eq("sat_rx_n", rx_wr, 32'd24);
        check_eq("sat_last_rx", 32'(rx_log[23]), 32'h010);

        clr_counts = 1'b1;
        @(negedge test_clk);
        clr_counts = 1'b0;
        check_eq("clr_counts", {20'd0, rx_count, tx_count, err_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
